// File: rtl/tl_mux_scheduler.sv
// ---------------------------------------------------------------------------
// tl_mux_scheduler
// Round-robin scheduler for the transaction-layer 4:1 port mux. Picks which
// of four first-word-fall-through source FIFOs (P0..P3) is popped each cycle,
// honours downstream back-pressure (stall), and forwards the popped word one
// cycle later on data_out/valid_out/grant_id. A grant may be held for up to
// cfg_burst consecutive pops (0 is treated as 1).
//
// The transaction-layer one-hot FSM (RESET, INIT, IDLE, ACTIVE) is driven
// straight onto the state output so its value can be observed directly.
//
// Optional build macro: TL_MUX_STRICT_P0_EN
//   defined   : source 0 has strict priority over the round-robin of 1..3.
//   undefined : pure round-robin over all four sources.
//
// Handshake: a source word is consumed on a rising edge exactly when its pop
// bit is high. pop is combinational and asserts only in ACTIVE with some req
// bit set and stall low. valid_out is a one-cycle strobe: it is high for the
// cycle after each pop edge and qualifies data_out/grant_id. There is no
// ready on the output side; stall is the only back-pressure.
// ---------------------------------------------------------------------------
module tl_mux_scheduler #(
  parameter int DATA_W  = 10,
  parameter int BURST_W = 3
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               init,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic [3:0]         req,
  input  logic [DATA_W-1:0]  P0,
  input  logic [DATA_W-1:0]  P1,
  input  logic [DATA_W-1:0]  P2,
  input  logic [DATA_W-1:0]  P3,
  input  logic               stall,
  output logic [3:0]         pop,
  output logic [DATA_W-1:0]  data_out,
  output logic               valid_out,
  output logic [1:0]         grant_id,
  output logic [3:0]         state,
  output logic               idle
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [BURST_W-1:0] burst_lim_q, burst_lim_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic [1:0]         grant_q, grant_d;

  logic               any_req;
  logic               keep;
  logic [1:0]         rr_sel;
  logic [1:0]         sel;
  logic               pop_en;
  logic               p0_strict;

  assign any_req = |req;

  // Keep the current owner while its burst is still open and it still requests.
  assign keep = req[owner_q] && (burst_cnt_q != '0) && (burst_cnt_q < burst_lim_q);

  // Round-robin scan owner+1, owner+2, owner+3, owner; scanning backwards lets
  // the nearest requester overwrite farther ones, so the first hit wins.
  always_comb begin
    rr_sel = owner_q;
    for (int k = 4; k >= 1; k--) begin
      if (req[2'(owner_q + 2'(k))]) begin
        rr_sel = 2'(owner_q + 2'(k));
      end
    end
  end

`ifdef TL_MUX_STRICT_P0_EN
  assign p0_strict = req[0];
`else
  assign p0_strict = 1'b0;
`endif

  // Final source choice: strict P0 (if built in), then burst keep, then scan.
  always_comb begin
    sel = rr_sel;
    if (p0_strict) begin
      sel = 2'd0;
    end else if (keep) begin
      sel = owner_q;
    end
  end

  // Pops happen only in ACTIVE, with something to pop and no back-pressure.
  assign pop_en = (state_q == ST_ACTIVE) && any_req && !stall;
  assign pop    = pop_en ? (4'b0001 << sel) : 4'b0000;

  // Next-state logic of the transaction-layer FSM; init outranks everything
  // except reset, which is handled asynchronously in the register block.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (init)         state_d = ST_INIT;
        else if (any_req) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)          state_d = ST_INIT;
        else if (!any_req) state_d = ST_IDLE;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  // Arbitration bookkeeping: config load in INIT, owner/burst update on pops.
  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    burst_lim_d = burst_lim_q;
    if (state_q == ST_INIT) begin
      burst_lim_d = (cfg_burst == '0) ? BURST_W'(1) : cfg_burst;
      owner_d     = 2'd3;
      burst_cnt_d = '0;
    end else if (pop_en && !p0_strict) begin
      // A strict-priority P0 pop leaves the 1..3 rotation untouched.
      if (sel == owner_q) begin
        burst_cnt_d = (burst_cnt_q >= burst_lim_q) ? burst_lim_q
                                                   : burst_cnt_q + BURST_W'(1);
      end else begin
        owner_d     = sel;
        burst_cnt_d = BURST_W'(1);
      end
    end
  end

  // Forwarding datapath: capture the popped head word one cycle after the pop.
  always_comb begin
    data_d  = data_q;
    grant_d = grant_q;
    valid_d = 1'b0;
    if (pop_en) begin
      valid_d = 1'b1;
      grant_d = sel;
      case (sel)
        2'd0:    data_d = P0;
        2'd1:    data_d = P1;
        2'd2:    data_d = P2;
        default: data_d = P3;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_RESET;
      owner_q     <= 2'd3;
      burst_cnt_q <= '0;
      burst_lim_q <= BURST_W'(1);
      data_q      <= '0;
      valid_q     <= 1'b0;
      grant_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      burst_lim_q <= burst_lim_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      grant_q     <= grant_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign grant_id  = grant_q;
  assign state     = state_q;
  assign idle      = (state_q == ST_IDLE);

endmodule

// File: tb/tb_tl_mux_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tl_mux_scheduler
// Directed bench for tl_mux_scheduler. Inputs change 1 time unit after each
// rising edge; outputs are checked on the falling edge. Every task starts and
// ends at that post-edge point.
// ---------------------------------------------------------------------------
module tb_tl_mux_scheduler;

  localparam int DATA_W  = 10;
  localparam int BURST_W = 3;

  logic               clk;
  logic               reset_L;
  logic               init;
  logic [BURST_W-1:0] cfg_burst;
  logic [3:0]         req;
  logic [DATA_W-1:0]  P0, P1, P2, P3;
  logic               stall;
  logic [3:0]         pop;
  logic [DATA_W-1:0]  data_out;
  logic               valid_out;
  logic [1:0]         grant_id;
  logic [3:0]         state;
  logic               idle;

  int n_cmp  = 0;
  int n_fail = 0;

  tl_mux_scheduler #(.DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .init      (init),
    .cfg_burst (cfg_burst),
    .req       (req),
    .P0        (P0),
    .P1        (P1),
    .P2        (P2),
    .P3        (P3),
    .stall     (stall),
    .pop       (pop),
    .data_out  (data_out),
    .valid_out (valid_out),
    .grant_id  (grant_id),
    .state     (state),
    .idle      (idle)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset, then a two-cycle init with cfg_burst=0 (limit becomes 1).
  task automatic test_reset();
    reset_L = 1'b0; init = 1'b0; cfg_burst = '0; req = 4'b1111; stall = 1'b0;
    P0 = '0; P1 = '0; P2 = '0; P3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (state !== 4'b0001) begin n_fail++; $display("FAIL reset_state: got %b expected %b", state, 4'b0001); end
    n_cmp++; if (pop !== 4'b0000) begin n_fail++; $display("FAIL reset_pop: got %b expected %b", pop, 4'b0000); end
    n_cmp++; if (valid_out !== 1'b0 || data_out !== 10'h000 || grant_id !== 2'd0 || idle !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got valid=%b data=%h grant=%0d idle=%b expected 0/000/0/0", valid_out, data_out, grant_id, idle); end
    next_cycle();
    reset_L = 1'b1; init = 1'b1; req = 4'b0000;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (state !== 4'b0010 || pop !== 4'b0000) begin n_fail++; $display("FAIL init_state1: got state=%b pop=%b expected 0010/0000", state, pop); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (state !== 4'b0010 || valid_out !== 1'b0) begin n_fail++; $display("FAIL init_state2: got state=%b valid=%b expected 0010/0", state, valid_out); end
    next_cycle();
    init = 1'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (state !== 4'b0100 || idle !== 1'b1 || pop !== 4'b0000) begin
      n_fail++; $display("FAIL init_to_idle: got state=%b idle=%b pop=%b expected 0100/1/0000", state, idle, pop); end
    next_cycle();
  endtask

  // All four requesting with burst 1: strict rotation 0,1,2,3,0,...
  task automatic test_round_robin();
    logic [DATA_W-1:0] pv [4];
    int prev;
    pv[0] = 10'h001; pv[1] = 10'h002; pv[2] = 10'h004; pv[3] = 10'h008;
    P0 = pv[0]; P1 = pv[1]; P2 = pv[2]; P3 = pv[3];
    req = 4'b1111;
    @(negedge clk);
    n_cmp++; if (pop !== 4'b0000) begin n_fail++; $display("FAIL rr_idle_bubble: got pop=%b expected 0000", pop); end
    next_cycle();
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (pop !== (4'b0001 << (i % 4))) begin n_fail++; $display("FAIL rr_pop[%0d]: got %b expected %b", i, pop, 4'b0001 << (i % 4)); end
      if (i == 0) begin
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rr_valid0: got %b expected 0", valid_out); end
      end else begin
        n_cmp++; if (valid_out !== 1'b1 || data_out !== pv[prev] || grant_id !== 2'(prev)) begin
          n_fail++; $display("FAIL rr_data[%0d]: got v=%b d=%h g=%0d expected 1/%h/%0d", i, valid_out, data_out, grant_id, pv[prev], prev); end
      end
      prev = i % 4;
      next_cycle();
    end
    req = 4'b0000;
    @(negedge clk);
    n_cmp++; if (valid_out !== 1'b1 || data_out !== 10'h008 || grant_id !== 2'd3 || pop !== 4'b0000) begin
      n_fail++; $display("FAIL rr_last: got v=%b d=%h g=%0d pop=%b expected 1/008/3/0000", valid_out, data_out, grant_id, pop); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (state !== 4'b0100 || idle !== 1'b1 || valid_out !== 1'b0) begin
      n_fail++; $display("FAIL rr_to_idle: got state=%b idle=%b valid=%b expected 0100/1/0", state, idle, valid_out); end
    next_cycle();
  endtask

  // Burst limit 2 over sources 0/1, including req[0] dropping mid-burst.
  task automatic test_burst_limit();
    logic [3:0] req_tab [13];
    int         exp_tab [13];
    logic [DATA_W-1:0] pv [4];
    int prev;
    req_tab = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0011};
    exp_tab = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0};
    pv[0] = 10'h0A1; pv[1] = 10'h0B2; pv[2] = 10'h3C3; pv[3] = 10'h3D4;
    P0 = pv[0]; P1 = pv[1]; P2 = pv[2]; P3 = pv[3];
    init = 1'b1; cfg_burst = 3'd2;
    next_cycle();
    init = 1'b0;
    @(negedge clk);
    n_cmp++; if (state !== 4'b0010) begin n_fail++; $display("FAIL burst_init: got state=%b expected 0010", state); end
    next_cycle();
    req = 4'b0011;
    @(negedge clk);
    n_cmp++; if (state !== 4'b0100 || pop !== 4'b0000) begin n_fail++; $display("FAIL burst_idle: got state=%b pop=%b expected 0100/0000", state, pop); end
    next_cycle();
    prev = -1;
    for (int i = 0; i < 13; i++) begin
      req = req_tab[i];
      @(negedge clk);
      n_cmp++; if (pop !== (4'b0001 << exp_tab[i])) begin n_fail++; $display("FAIL burst_pop[%0d]: got %b expected %b", i, pop, 4'b0001 << exp_tab[i]); end
      if (prev >= 0) begin
        n_cmp++; if (valid_out !== 1'b1 || data_out !== pv[prev] || grant_id !== 2'(prev)) begin
          n_fail++; $display("FAIL burst_data[%0d]: got v=%b d=%h g=%0d expected 1/%h/%0d", i, valid_out, data_out, grant_id, pv[prev], prev); end
      end
      prev = exp_tab[i];
      next_cycle();
    end
    req = 4'b0000;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (state !== 4'b0100) begin n_fail++; $display("FAIL burst_to_idle: got state=%b expected 0100", state); end
    next_cycle();
  endtask

  // Stall held for three cycles while source 2 requests.
  task automatic test_back_pressure();
    P2 = 10'h315; req = 4'b0100; stall = 1'b1;
    @(negedge clk);
    n_cmp++; if (pop !== 4'b0000 || valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got pop=%b valid=%b expected 0000/0", pop, valid_out); end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (pop !== 4'b0000 || valid_out !== 1'b0 || state !== 4'b1000) begin
        n_fail++; $display("FAIL bp_stall[%0d]: got pop=%b valid=%b state=%b expected 0000/0/1000", i, pop, valid_out, state); end
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    n_cmp++; if (pop !== 4'b0100) begin n_fail++; $display("FAIL bp_release_pop: got %b expected 0100", pop); end
    next_cycle();
    req = 4'b0000;
    @(negedge clk);
    n_cmp++; if (valid_out !== 1'b1 || data_out !== 10'h315 || grant_id !== 2'd2) begin
      n_fail++; $display("FAIL bp_data: got v=%b d=%h g=%0d expected 1/315/2", valid_out, data_out, grant_id); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (valid_out !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL bp_to_idle: got valid=%b idle=%b expected 0/1", valid_out, idle); end
    next_cycle();
  endtask

  // IDLE -> ACTIVE on a single request from source 3, and back again.
  task automatic test_idle_active();
    P3 = 10'h26E; req = 4'b1000;
    @(negedge clk);
    n_cmp++; if (state !== 4'b0100 || pop !== 4'b0000) begin n_fail++; $display("FAIL ia_n: got state=%b pop=%b expected 0100/0000", state, pop); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (state !== 4'b1000 || pop !== 4'b1000 || idle !== 1'b0) begin
      n_fail++; $display("FAIL ia_n1: got state=%b pop=%b idle=%b expected 1000/1000/0", state, pop, idle); end
    next_cycle();
    req = 4'b0000;
    @(negedge clk);
    n_cmp++; if (valid_out !== 1'b1 || data_out !== 10'h26E || grant_id !== 2'd3) begin
      n_fail++; $display("FAIL ia_n2_data: got v=%b d=%h g=%0d expected 1/26e/3", valid_out, data_out, grant_id); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (state !== 4'b0100 || idle !== 1'b1) begin n_fail++; $display("FAIL ia_back_idle: got state=%b idle=%b expected 0100/1", state, idle); end
    next_cycle();
  endtask

  // Asynchronous reset asserted between edges while ACTIVE.
  task automatic test_async_reset();
    req = 4'b1111;
    next_cycle();
    @(negedge clk);
    // Owner 3 still has an open burst (1 of 2) from the previous test.
    n_cmp++; if (pop !== 4'b1000) begin n_fail++; $display("FAIL ar_active_pop: got %b expected 1000", pop); end
    @(posedge clk);
    #3;
    n_cmp++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b expected 1", valid_out); end
    reset_L = 1'b0;
    #1;
    n_cmp++; if (pop !== 4'b0000 || valid_out !== 1'b0 || state !== 4'b0001 || data_out !== 10'h000) begin
      n_fail++; $display("FAIL ar_immediate: got pop=%b valid=%b state=%b data=%h expected 0000/0/0001/000", pop, valid_out, state, data_out); end
    next_cycle();
  endtask

`ifdef TL_MUX_STRICT_P0_EN
  // Source 0 wins whenever it requests; 1 and 3 alternate once it stops.
  task automatic test_strict_p0();
    reset_L = 1'b1; init = 1'b1; cfg_burst = 3'd1; req = 4'b0000;
    P0 = 10'h111; P1 = 10'h122; P3 = 10'h133;
    next_cycle();
    init = 1'b0;
    next_cycle();
    req = 4'b1011;
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (pop !== 4'b0001) begin n_fail++; $display("FAIL strict_p0[%0d]: got %b expected 0001", i, pop); end
      next_cycle();
    end
    req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (pop !== ((i % 2 == 0) ? 4'b0010 : 4'b1000)) begin
        n_fail++; $display("FAIL strict_rr[%0d]: got %b expected %b", i, pop, (i % 2 == 0) ? 4'b0010 : 4'b1000); end
      next_cycle();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_burst_limit();
    test_back_pressure();
    test_idle_active();
    test_async_reset();
`ifdef TL_MUX_STRICT_P0_EN
    test_strict_p0();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
